// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state encodings, error codes and default sync marker for the UART frame controller.
package uart_frame_pkg;
  typedef enum logic [2:0] {HUNT, ADDR, LEN, DATA, CHK, COMMIT} state_e;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_frame_chk.sv
// uart_frame_chk: byte-wise frame checksum accumulator; XOR by default, CRC-8 (poly 0x07) when UART_FRAME_CRC8_EN is defined.
module uart_frame_chk (
  input  logic       clk,
  input  logic       i_Rst,
  input  logic       i_Clear,
  input  logic       i_En,
  input  logic [7:0] i_Byte,
  output logic [7:0] o_Chk
);
  logic [7:0] chk_q, chk_d;
`ifdef UART_FRAME_CRC8_EN
  // Whole byte folded in one cycle, so the result is ready before the next receiver byte.
  always_comb begin
    chk_d = chk_q ^ i_Byte;
    for (int i = 0; i < 8; i++) chk_d = chk_d[7] ? {chk_d[6:0], 1'b0} ^ 8'h07 : {chk_d[6:0], 1'b0};
  end
`else
  assign chk_d = chk_q ^ i_Byte;
`endif
  always_ff @(posedge clk) begin
    if (i_Rst || i_Clear) chk_q <= '0;
    else if (i_En) chk_q <= chk_d;
  end
  assign o_Chk = chk_q;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: turns SYNC/ADDR/LEN/DATA/CHK byte frames into handshaked register writes.
// Define UART_FRAME_CRC8_EN to switch the frame checksum from XOR to CRC-8.
module uart_rx_frame_ctrl import uart_frame_pkg::*; #(
  parameter int         FREQUENCY     = 87,
  parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       i_Rst,
  input  logic       i_DV,
  input  logic [7:0] i_Byte,
  output logic       o_Wr_En,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  input  logic       i_Wr_Ready,
  output logic       o_Frame_Ok,
  output logic       o_Err,
  output logic [2:0] o_Err_Code,
  output logic       o_Busy
);
  localparam int T  = TIMEOUT_BYTES * 10 * FREQUENCY;
  localparam int CW = $clog2(T + 1);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(T - 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d, len_q, len_d, idx_q, idx_d, idx_nx;
  logic [7:0] buf_q [MAX_LEN];
  logic ovr_q, ovr_d, wr_en_q, wr_en_d, ok_q, ok_d, err_q, err_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, chk;
  logic [2:0] code_q, code_d;
  logic timed, tmo, acc, last, done, len_bad, len_err, chk_ok, chk_err;
  uart_frame_chk u_chk (
    .clk    (clk),
    .i_Rst  (i_Rst),
    .i_Clear(state_q == HUNT),
    .i_En   (i_DV && state_q inside {ADDR, LEN, DATA}),
    .i_Byte (i_Byte),
    .o_Chk  (chk)
  );
  assign timed   = state_q inside {ADDR, LEN, DATA, CHK};
  assign tmo     = timed && !i_DV && cnt_q == T_LAST;
  assign cnt_d   = (i_DV || !timed) ? '0 : cnt_q + 1'b1;
  assign idx_nx  = idx_q + 8'd1;
  assign last    = idx_nx == len_q;
  assign acc     = state_q == COMMIT && wr_en_q && i_Wr_Ready;
  assign done    = acc && last;
  assign len_bad = i_Byte == 8'd0 || i_Byte > MAX_B;
  assign len_err = state_q == LEN && i_DV && len_bad;
  assign chk_ok  = state_q == CHK && i_DV && i_Byte == chk;
  assign chk_err = state_q == CHK && i_DV && i_Byte != chk;
  always_ff @(posedge clk) begin
    if (i_Rst) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      ovr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      ovr_q     <= ovr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end
  always_ff @(posedge clk) if (state_q == DATA && i_DV) buf_q[idx_q[IW-1:0]] <= i_Byte;
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (i_DV && i_Byte == SYNC_BYTE) state_d = ADDR;
      ADDR:    if (i_DV) state_d = LEN;
      LEN:     if (i_DV) state_d = len_bad ? HUNT : DATA;
      DATA:    if (i_DV && last) state_d = CHK;
      CHK:     if (i_DV) state_d = chk_ok ? COMMIT : HUNT;
      COMMIT:  if (done) state_d = HUNT;
      default: state_d = HUNT;
    endcase
    if (tmo) state_d = HUNT;
  end
  // A byte landing during COMMIT is dropped but remembered so completion reports overrun.
  always_comb begin
    addr_d    = state_q == ADDR && i_DV ? i_Byte : addr_q;
    len_d     = state_q == LEN && i_DV ? i_Byte : len_q;
    idx_d     = (state_q == DATA && i_DV) || acc ? idx_nx : state_q inside {LEN, CHK} && i_DV ? 8'd0 : idx_q;
    ovr_d     = state_q == COMMIT && (ovr_q || i_DV);
    wr_en_d   = chk_ok || (wr_en_q && !done);
    wr_addr_d = chk_ok ? addr_q : acc ? addr_q + idx_nx : wr_addr_q;
    wr_data_d = chk_ok ? buf_q[0] : acc && !last ? buf_q[idx_nx[IW-1:0]] : wr_data_q;
    ok_d      = done && !ovr_d;
    err_d     = len_err || chk_err || tmo || (done && ovr_d);
    code_d    = ok_d ? ERR_NONE : !err_d ? code_q : tmo ? ERR_TIMEOUT : len_err ? ERR_LEN :
                chk_err ? ERR_CHK : ERR_OVERRUN;
  end
  assign o_Wr_En    = wr_en_q;
  assign o_Wr_Addr  = wr_addr_q;
  assign o_Wr_Data  = wr_data_q;
  assign o_Frame_Ok = ok_q;
  assign o_Err      = err_q;
  assign o_Err_Code = code_q;
  assign o_Busy     = state_q != HUNT;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: scoreboard bench with a frame-level reference model for uart_rx_frame_ctrl.
module tb_uart_rx_frame_ctrl;
  localparam int FREQ = 2, TB = 4, MAXL = 16, T = TB * 10 * FREQ;
  localparam logic [7:0] SYNC = 8'hA5;
  logic clk = 1'b0, i_Rst = 1'b1, i_DV = 1'b0, i_Wr_Ready = 1'b0;
  logic [7:0] i_Byte = 8'h00;
  logic o_Wr_En, o_Frame_Ok, o_Err, o_Busy;
  logic [7:0] o_Wr_Addr, o_Wr_Data;
  logic [2:0] o_Err_Code;
  int checks = 0, errors = 0, accepts = 0, rdy_mode = 1;
  logic [15:0] exp_wr[$];
  int exp_ev[$];
  logic [7:0] fr[$];
  logic rdy_pat[$];
  logic prev_stall = 1'b0;
  logic [15:0] prev_wr = '0;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.FREQUENCY(FREQ), .SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .TIMEOUT_BYTES(TB)) dut (
    .clk(clk), .i_Rst(i_Rst), .i_DV(i_DV), .i_Byte(i_Byte),
    .o_Wr_En(o_Wr_En), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data), .i_Wr_Ready(i_Wr_Ready),
    .o_Frame_Ok(o_Frame_Ok), .o_Err(o_Err), .o_Err_Code(o_Err_Code), .o_Busy(o_Busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Checksum from its definition: plain XOR, or CRC-8 as bit-serial polynomial division.
  function automatic logic [7:0] csum(input logic [7:0] q[$], input int lo, input int hi);
    logic [7:0] c = 8'h00;
    for (int i = lo; i <= hi; i++) begin
`ifdef UART_FRAME_CRC8_EN
      for (int k = 7; k >= 0; k--) begin
        logic fb;
        fb = c[7] ^ q[i][k];
        c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
`else
      c = c ^ q[i];
`endif
    end
    return c;
  endfunction

  // Frame-level model: collects a frame's bytes and judges it once complete; returns 1 when a commit starts.
  function automatic bit model(input logic [7:0] b, input int idle, input bit ovr);
    int n;
    if (fr.size() != 0 && idle >= T) begin
      exp_ev.push_back(3);
      fr.delete();
    end
    if (fr.size() == 0) begin
      if (b == SYNC) fr.push_back(b);
      return 1'b0;
    end
    fr.push_back(b);
    n = fr.size();
    if (n == 3 && (b == 8'd0 || b > MAXL)) begin
      exp_ev.push_back(1);
      fr.delete();
    end else if (n > 3 && n == int'(fr[2]) + 4) begin
      if (b == csum(fr, 1, n - 2)) begin
        for (int i = 0; i < int'(fr[2]); i++) exp_wr.push_back({8'(fr[1] + 8'(i)), fr[3 + i]});
        exp_ev.push_back(ovr ? 4 : 0);
        fr.delete();
        return 1'b1;
      end
      exp_ev.push_back(2);
      fr.delete();
    end
    return 1'b0;
  endfunction

  task automatic pulse(input logic [7:0] b, input int idle);
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    i_DV = 1'b1;
    i_Byte = b;
    @(posedge clk);
    #1;
    i_DV = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_Busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("commit_done", {31'd0, o_Busy}, 32'd0);
  endtask

  task automatic send(input logic [7:0] b, input int idle, input bit ovr);
    bit c;
    c = model(b, idle, ovr);
    pulse(b, idle);
    if (c && !ovr) wait_idle();
  endtask

  task automatic frame(input logic [7:0] addr, input int len, input logic [127:0] d, input logic [7:0] xr,
                       input int idle, input bit ovr);
    logic [7:0] q[$];
    q.push_back(SYNC);
    q.push_back(addr);
    q.push_back(8'(len));
    if (len >= 1 && len <= MAXL) begin
      for (int i = 0; i < len; i++) q.push_back(d[8*i +: 8]);
      q.push_back(csum(q, 1, q.size() - 1) ^ xr);
    end
    for (int i = 0; i < q.size(); i++) send(q[i], idle, ovr && i == q.size() - 1);
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outs", {o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Ok, o_Err, o_Err_Code, o_Busy}, 32'd0);
    i_Rst = 1'b0;
    fr.delete();
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) i_Wr_Ready = $urandom_range(0, 3) != 0;
    else if (rdy_mode == 1) i_Wr_Ready = 1'b1;
    else begin
      i_Wr_Ready = 1'b0;
      if (rdy_mode == 2 && o_Wr_En && rdy_pat.size() > 0) i_Wr_Ready = rdy_pat.pop_front();
    end
  end

  always @(negedge clk) begin
    if (i_Rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("stall_hold", {o_Wr_En, o_Wr_Addr, o_Wr_Data}, {1'b1, prev_wr});
      prev_stall = o_Wr_En && !i_Wr_Ready;
      prev_wr = {o_Wr_Addr, o_Wr_Data};
      if (o_Wr_En && i_Wr_Ready) begin
        accepts++;
        if (exp_wr.size() == 0) chk("unexpected_wr", {16'd0, o_Wr_Addr, o_Wr_Data}, 32'hFFFF_FFFF);
        else chk("wr_addr_data", {16'd0, o_Wr_Addr, o_Wr_Data}, {16'd0, exp_wr.pop_front()});
      end
      if (o_Frame_Ok || o_Err) begin
        chk("ok_err_excl", {31'd0, o_Frame_Ok & o_Err}, 32'd0);
        if (exp_ev.size() == 0) chk("unexpected_event", {o_Frame_Ok, o_Err, o_Err_Code}, 32'hFFFF_FFFF);
        else begin
          int e;
          e = exp_ev.pop_front();
          chk("event", {o_Frame_Ok, o_Err, o_Err_Code}, e == 0 ? 32'h10 : {27'd0, 2'b01, 3'(e)});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, idle, kind, len;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Ok, o_Err, o_Err_Code, o_Busy}, 32'd0);
    i_Rst = 1'b0;
    rdy_mode = 1;
    frame(8'h10, 2, 128'h2211, 8'h00, 0, 1'b0);
    frame(8'h10, 2, 128'h2211, 8'h01, 0, 1'b0);
    frame(8'h10, 2, 128'h2211, 8'h00, 1, 1'b0);
    frame(8'h10, 0, 128'h0, 8'h00, 0, 1'b0);
    frame(8'h10, 17, 128'h0, 8'h00, 0, 1'b0);
    frame(8'h30, 1, 128'h5A, 8'h00, 0, 1'b0);
    send(SYNC, 0, 1'b0);
    send(8'h10, 0, 1'b0);
    send(8'h02, 0, 1'b0);
    send(8'h11, 0, 1'b0);
    send(8'h22, T, 1'b0);
    frame(8'h10, 2, 128'h2211, 8'h00, T - 1, 1'b0);
    rdy_mode = 2;
    rdy_pat.delete();
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    a0 = accepts;
    frame(8'hFF, 2, 128'h0201, 8'h00, 0, 1'b0);
    chk("wrap_accepts", accepts - a0, 2);
    rdy_mode = 1;
    send(SYNC, 0, 1'b0);
    send(8'h10, 0, 1'b0);
    send(8'h03, 0, 1'b0);
    send(8'h11, 0, 1'b0);
    do_reset();
    frame(8'h10, 2, 128'h2211, 8'h00, 0, 1'b0);
    rdy_mode = 3;
    frame(8'h40, 3, 128'h332211, 8'h00, 0, 1'b1);
    pulse(8'h77, 0);
    rdy_mode = 1;
    wait_idle();
    send(SYNC, 2, 1'b0);
    send(8'h10, 0, 1'b0);
    send(8'h02, 0, 1'b0);
    send(8'h11, 0, 1'b0);
    send(8'h22, 0, 1'b0);
    send(8'h21, 0, 1'b0);
    for (int f = 0; f < 30; f++) begin
      rdy_mode = f % 3 == 0 ? 1 : 0;
      kind = $urandom_range(0, 9);
      len = kind == 0 ? 0 : kind == 1 ? MAXL + 1 + $urandom_range(0, 60) : $urandom_range(1, MAXL);
      idle = $urandom_range(0, 11);
      idle = idle == 10 ? T - 1 : idle == 11 ? T : idle % 3;
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)), 1, 1'b0);
      frame(8'($urandom), len, {$urandom, $urandom, $urandom, $urandom}, kind == 2 ? 8'h01 : 8'h00, idle, 1'b0);
    end
    rdy_mode = 1;
    send(8'h00, T + 2, 1'b0);
    wait_idle();
    repeat (20) @(posedge clk);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("event_queue_drained", exp_ev.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
